// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback select, 31x32 register file (x0 hardwired to
// zero) with one write port and two combinational read ports, plus a counter
// of retired valid instructions.
// Optional feature: define WB_BYPASS_EN for write-through reads. When it is
// defined, a read of the register being written this cycle returns wb_data.
// When it is undefined, that read returns the value stored before the write.
module writeback_regfile #(
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic             wb_reg_en,
  input  logic [4:0]       wb_rd,
  input  logic [1:0]       mem_reg_in,
  input  logic [31:0]      alu_res_in,
  input  logic [31:0]      wrap_load_in,
  input  logic [31:0]      next_sel_addr_in,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [31:0]      rs1_data,
  output logic [31:0]      rs2_data,
  output logic [31:0]      wb_data,
  output logic [RET_W-1:0] retired
);

  // x0 is not stored; entries 1..31 hold the architectural registers.
  logic [31:0]      regs_q [1:31];
  logic [RET_W-1:0] retired_q;
  logic [RET_W-1:0] retired_d;
  logic             wr_en_s;

  // The write only happens for a real instruction with a nonzero destination.
  assign wr_en_s = wb_valid & wb_reg_en & (wb_rd != 5'd0);

  // Writeback source mux. The reserved select drives a defined zero.
  always_comb begin
    wb_data = 32'h0000_0000;
    case (mem_reg_in)
      2'b00:   wb_data = alu_res_in;
      2'b01:   wb_data = wrap_load_in;
      2'b10:   wb_data = next_sel_addr_in;
      2'b11:   wb_data = 32'h0000_0000;
      default: wb_data = 32'h0000_0000;
    endcase
  end

  // Read port 1. It returns zero for x0, then checks the optional
  // write-through path, then falls back to the stored value.
  always_comb begin
    rs1_data = 32'h0000_0000;
    if (rs1_addr == 5'd0) begin
      rs1_data = 32'h0000_0000;
`ifdef WB_BYPASS_EN
    end else if (wr_en_s && (rs1_addr == wb_rd)) begin
      rs1_data = wb_data;
`endif
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  // Read port 2. It is identical to port 1, so both ports agree on the same index.
  always_comb begin
    rs2_data = 32'h0000_0000;
    if (rs2_addr == 5'd0) begin
      rs2_data = 32'h0000_0000;
`ifdef WB_BYPASS_EN
    end else if (wr_en_s && (rs2_addr == wb_rd)) begin
      rs2_data = wb_data;
`endif
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

  // Next value of the retired counter. Every valid slot counts, even with no
  // register write, and the count wraps naturally.
  always_comb begin
    retired_d = retired_q;
    if (wb_valid) begin
      retired_d = retired_q + {{(RET_W-1){1'b0}}, 1'b1};
    end else begin
      retired_d = retired_q;
    end
  end

  // Register array update. Reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else if (wr_en_s) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Retired counter register. Reset discards that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile.
// The reference model is a plain array of 32 words plus an integer retire count.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_reg_en;
  logic [4:0]  wb_rd;
  logic [1:0]  mem_reg_in;
  logic [31:0] alu_res_in;
  logic [31:0] wrap_load_in;
  logic [31:0] next_sel_addr_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic [31:0] retired;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl_regs [0:31];
  logic [31:0] mdl_ret;

  writeback_regfile #(.RET_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_valid         (wb_valid),
    .wb_reg_en        (wb_reg_en),
    .wb_rd            (wb_rd),
    .mem_reg_in       (mem_reg_in),
    .alu_res_in       (alu_res_in),
    .wrap_load_in     (wrap_load_in),
    .next_sel_addr_in (next_sel_addr_in),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .wb_data          (wb_data),
    .retired          (retired)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_wb();
    case (mem_reg_in)
      2'b00:   return alu_res_in;
      2'b01:   return wrap_load_in;
      2'b10:   return next_sel_addr_in;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_we();
    return wb_valid && wb_reg_en && (wb_rd != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (exp_we() && a == wb_rd) return exp_wb();
`endif
    return mdl_regs[a];
  endfunction

  task automatic set_idle();
    rst = 1'b0; wb_valid = 1'b0; wb_reg_en = 1'b0; wb_rd = 5'd0; mem_reg_in = 2'b00;
    alu_res_in = 32'h0; wrap_load_in = 32'h0; next_sel_addr_in = 32'h0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
  endtask

  // Inputs are already applied. This checks the combinational outputs, clocks
  // one edge, updates the model and checks the counter. It ends at a negedge.
  task automatic step();
    logic [31:0] w;
    logic        we;
    #1;
    w  = exp_wb();
    we = exp_we();
    check_val("wb_data", wb_data, w);
    check_val("rs1_data", rs1_data, exp_read(rs1_addr));
    check_val("rs2_data", rs2_data, exp_read(rs2_addr));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
      mdl_ret = 32'h0;
    end else begin
      if (we) mdl_regs[wb_rd] = w;
      if (wb_valid) mdl_ret = mdl_ret + 32'd1;
    end
    #1;
    check_val("retired", retired, mdl_ret);
    @(negedge clk);
  endtask

  task automatic do_write(input logic v, input logic en, input logic [4:0] rd,
                          input logic [1:0] sel, input logic [31:0] val);
    wb_valid = v; wb_reg_en = en; wb_rd = rd; mem_reg_in = sel;
    alu_res_in = val; wrap_load_in = val; next_sel_addr_in = val;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
    mdl_ret = 32'h0;
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Hold reset and read all 32 indices on both ports.
    for (int i = 0; i < 32; i++) begin
      rst = 1'b1;
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      step();
    end
    set_idle();
    check_val("reset_retired", retired, 32'h0);

    // Write x5 through the ALU select, then read it back on the next cycle.
    do_write(1'b1, 1'b1, 5'd5, 2'b00, 32'hDEAD_BEEF);
    step();
    set_idle(); rs1_addr = 5'd5;
    step();
    check_val("x5_direct", rs1_data, 32'hDEAD_BEEF);
    check_val("ret_after_x5", retired, 32'd1);

    // A write to x0 is discarded, but the instruction still retires.
    do_write(1'b1, 1'b1, 5'd0, 2'b01, 32'h1234_5678);
    step();
    set_idle();
    step();
    check_val("x0_zero", rs1_data, 32'h0);
    check_val("ret_after_x0", retired, 32'd2);

    // Same-cycle write and read of x7 through the next-PC select.
    do_write(1'b1, 1'b1, 5'd7, 2'b10, 32'h0000_0104);
    rs2_addr = 5'd7;
    #1;
`ifdef WB_BYPASS_EN
    check_val("x7_bypass", rs2_data, 32'h0000_0104);
`else
    check_val("x7_nobypass", rs2_data, 32'h0);
`endif
    step();

    // A bubble does not write, even with wb_reg_en set.
    do_write(1'b0, 1'b1, 5'd3, 2'b00, 32'hFFFF_FFFF);
    rs1_addr = 5'd3;
    step();
    set_idle(); rs1_addr = 5'd3;
    step();
    check_val("x3_bubble", rs1_data, 32'h0);
    check_val("ret_bubble", retired, 32'd3);

    // The reserved select writes zero over a nonzero value.
    do_write(1'b1, 1'b1, 5'd5, 2'b11, 32'h5555_5555);
    step();
    set_idle(); rs1_addr = 5'd5;
    step();
    check_val("x5_sel11", rs1_data, 32'h0);

    // Reset in the same cycle as a write of x9 discards that write.
    do_write(1'b1, 1'b1, 5'd9, 2'b00, 32'hA5A5_A5A5);
    step();
    do_write(1'b1, 1'b1, 5'd9, 2'b00, 32'h0000_0001);
    rst = 1'b1;
    step();
    set_idle(); rs1_addr = 5'd9; rs2_addr = 5'd9;
    step();
    check_val("x9_after_rst", rs1_data, 32'h0);
    check_val("ret_after_rst", retired, 32'h0);

    // Randomized traffic. Reads often target the write index.
    for (int n = 0; n < 400; n++) begin
      rst              = ($urandom_range(0, 49) == 0);
      wb_valid         = 1'($urandom);
      wb_reg_en        = 1'($urandom);
      wb_rd            = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      mem_reg_in       = 2'($urandom);
      alu_res_in       = $urandom;
      wrap_load_in     = $urandom;
      next_sel_addr_in = $urandom;
      rs1_addr         = ($urandom_range(0, 2) == 0) ? wb_rd : 5'($urandom);
      rs2_addr         = ($urandom_range(0, 2) == 0) ? wb_rd : 5'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
